// File: rtl/seg_pkg.sv
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared constants and the digit-enable decode for the 4-digit scanner.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = 2;

    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = 4'b1111;
    localparam logic [NUM_DIGITS-1:0] DIG_EN_0 = 4'b1110;
    localparam logic [NUM_DIGITS-1:0] DIG_EN_1 = 4'b1101;
    localparam logic [NUM_DIGITS-1:0] DIG_EN_2 = 4'b1011;
    localparam logic [NUM_DIGITS-1:0] DIG_EN_3 = 4'b0111;

    function automatic logic [NUM_DIGITS-1:0] digEnDecode(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] en;
        case (idx)
            2'd0:    en = DIG_EN_0;
            2'd1:    en = DIG_EN_1;
            2'd2:    en = DIG_EN_2;
            default: en = DIG_EN_3;
        endcase
        return en;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_tick_gen.sv
// ============================================================================
//  Module   : seg_tick_gen
//  Purpose  : Digit-slot prescaler; flags the last cycle of a slot and its dead time.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_tick_gen #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick,
    output logic o_inDead
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick   = (r_cnt == C_LAST);
    assign o_inDead = (int'(r_cnt) < DEAD_CYCLES);

endmodule

`default_nettype wire

// File: rtl/seg_scan.sv
// ============================================================================
//  Module   : seg_scan
//  Purpose  : Double-buffered 4-digit multiplex scanner feeding the hex decoder.
//             Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] iValue,
    input  logic [3:0]  iDpMask,
    input  logic        iLoad,
    output logic [3:0]  oNum,
    output logic [3:0]  oDigEn,
    output logic        oDp,
    output logic        oFrame
);

    logic w_tick;
    logic w_inDead;
    logic w_wrap;
    logic [3:0] w_nib;
    logic [NUM_DIGITS-1:0] w_blank;

    logic [IDX_W-1:0] r_idx;
    logic [15:0] r_shadowVal;
    logic [15:0] r_pendVal;
    logic [3:0]  r_shadowDp;
    logic [3:0]  r_pendDp;
    logic        r_pendFlag;

    seg_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .o_tick   (w_tick),
        .o_inDead (w_inDead)
    );

    assign w_wrap = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_nib  = r_shadowVal[4*r_idx +: 4];

`ifdef SEG_SCAN_LZB_EN
    // A digit blanks only when it and every digit to its left are zero.
    always_comb begin
        w_blank    = '0;
        w_blank[3] = (r_shadowVal[15:12] == 4'h0);
        w_blank[2] = w_blank[3] && (r_shadowVal[11:8] == 4'h0);
        w_blank[1] = w_blank[2] && (r_shadowVal[7:4] == 4'h0);
    end
`else
    assign w_blank = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // A load landing on the wrap tick bypasses the pending buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadowVal <= '0;
            r_shadowDp  <= '0;
            r_pendVal   <= '0;
            r_pendDp    <= '0;
            r_pendFlag  <= 1'b0;
        end else if (w_wrap) begin
            if (iLoad) begin
                r_shadowVal <= iValue;
                r_shadowDp  <= iDpMask;
            end else if (r_pendFlag) begin
                r_shadowVal <= r_pendVal;
                r_shadowDp  <= r_pendDp;
            end
            r_pendFlag <= 1'b0;
        end else if (iLoad) begin
            r_pendVal  <= iValue;
            r_pendDp   <= iDpMask;
            r_pendFlag <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oNum   <= 4'h0;
            oDigEn <= DIG_OFF;
            oDp    <= 1'b1;
            oFrame <= 1'b0;
        end else begin
            oNum   <= w_nib;
            oDigEn <= (w_inDead || w_blank[r_idx]) ? DIG_OFF : digEnDecode(r_idx);
            oDp    <= w_blank[r_idx] ? 1'b1 : ~r_shadowDp[r_idx];
            oFrame <= w_wrap;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan.sv
// ============================================================================
//  Module   : tb_seg_scan
//  Purpose  : Directed self-checking bench for seg_scan (REFRESH_DIV=4, DEAD_CYCLES=1).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_scan;

    localparam int RDIV = 4;
    localparam int DEAD = 1;

`ifdef SEG_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    // Expected blanking masks for the values used, written out by hand.
    localparam logic [3:0] BL_ZERO = LZB ? 4'b1110 : 4'b0000;
    localparam logic [3:0] BL_0F0F = LZB ? 4'b1000 : 4'b0000;
    localparam logic [3:0] BL_0050 = LZB ? 4'b1100 : 4'b0000;
    localparam logic [3:0] BL_NONE = 4'b0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] iValue;
    logic [3:0]  iDpMask;
    logic        iLoad;
    logic [3:0]  oNum;
    logic [3:0]  oDigEn;
    logic        oDp;
    logic        oFrame;

    int passCnt  = 0;
    int totalCnt = 0;
    int frameNo  = 0;
    int stepNo   = 0;

    seg_scan #(
        .REFRESH_DIV (RDIV),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .iValue  (iValue),
        .iDpMask (iDpMask),
        .iLoad   (iLoad),
        .oNum    (oNum),
        .oDigEn  (oDigEn),
        .oDp     (oDp),
        .oFrame  (oFrame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s frame %0d step %0d: got %b expected %b", tag, frameNo, stepNo, obs, exp);
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_en"},    oDigEn,           4'b1111);
        chk({tag, "_num"},   oNum,             4'h0);
        chk({tag, "_dp"},    {3'b000, oDp},    4'b0001);
        chk({tag, "_frame"}, {3'b000, oFrame}, 4'b0000);
    endtask

    // Steps through one frame from digit 0, optionally strobing up to two loads.
    task automatic runFrame(input int nSteps,
                            input logic [15:0] expVal, input logic [3:0] expDp,
                            input logic [3:0] expBl,
                            input int ldA, input logic [15:0] vA, input logic [3:0] dA,
                            input int ldB, input logic [15:0] vB, input logic [3:0] dB);
        frameNo++;
        for (int j = 0; j < nSteps; j++) begin
            int slot;
            logic [3:0] eEn;
            logic [3:0] eNum;
            logic       eDp;
            iLoad = (j == ldA) || (j == ldB);
            if (j == ldA) begin
                iValue  = vA;
                iDpMask = dA;
            end else if (j == ldB) begin
                iValue  = vB;
                iDpMask = dB;
            end
            tick1();
            iLoad  = 1'b0;
            stepNo = j;
            slot   = j / RDIV;
            eNum   = expVal[4*slot +: 4];
            eEn    = ((j % RDIV) < DEAD || expBl[slot]) ? 4'b1111 : ~(4'b0001 << slot);
            eDp    = expBl[slot] ? 1'b1 : ~expDp[slot];
            chk("en",    oDigEn,           eEn);
            chk("num",   oNum,             eNum);
            chk("dp",    {3'b000, oDp},    {3'b000, eDp});
            chk("frame", {3'b000, oFrame}, {3'b000, (j == 15)});
        end
    endtask

    initial begin
        rst     = 1'b1;
        iLoad   = 1'b0;
        iValue  = 16'h0000;
        iDpMask = 4'b0000;
        tick1();
        tick1();
        tick1();
        checkReset("rst_hold");
        rst = 1'b0;

        // Frame 1: blank value, enable walk 1110/1101/1011/0111 after a dead cycle.
        runFrame(16, 16'h0000, 4'b0000, BL_ZERO, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        // Frame 2: mid-frame load must not show yet.
        runFrame(16, 16'h0000, 4'b0000, BL_ZERO, 5, 16'h12AB, 4'b0100, -1, 16'h0, 4'h0);
        // Frame 3: 12AB visible; load coincident with the wrap tick.
        runFrame(16, 16'h12AB, 4'b0100, BL_NONE, 15, 16'h0F0F, 4'b0001, -1, 16'h0, 4'h0);
        // Frame 4: 0F0F visible; two loads, last one wins.
        runFrame(16, 16'h0F0F, 4'b0001, BL_0F0F, 3, 16'h1111, 4'b0000, 10, 16'h2222, 4'b0000);
        // Frame 5: 2222 visible; load then reset inside slot 2.
        runFrame(10, 16'h2222, 4'b0000, BL_NONE, 2, 16'h9999, 4'b1111, -1, 16'h0, 4'h0);
        rst = 1'b1;
        tick1();
        checkReset("rst_mid1");
        tick1();
        checkReset("rst_mid2");
        rst = 1'b0;

        // Frames 6-7: pending data from before reset must never surface.
        runFrame(16, 16'h0000, 4'b0000, BL_ZERO, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        runFrame(16, 16'h0000, 4'b0000, BL_ZERO, 7, 16'h0050, 4'b0000, -1, 16'h0, 4'h0);
        // Frames 8-9: leading-zero cases.
        runFrame(16, 16'h0050, 4'b0000, BL_0050, 12, 16'h0000, 4'b0001, -1, 16'h0, 4'h0);
        runFrame(16, 16'h0000, 4'b0001, BL_ZERO, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

`default_nettype wire
